// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the pipelined multiply/divide unit.
// Holds the op encodings, the FSM state encoding and the divide-by-zero quotient.
// Both are used by pipe_mdu and by the execute stage.
package mdu_pkg;

  // Operation encodings as presented on the op port
  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  // FSM state encoding (2 bits, legacy-compatible constants)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Default datapath width and the quotient returned on divide by zero
  localparam int unsigned MDU_W = 32;
  localparam logic [MDU_W-1:0] DIV0_QUOT = {MDU_W{1'b1}};

  // Divide ops have bit 1 set
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // MULT and DIV are the signed variants (bit 0 clear)
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/pipe_mdu_if.sv
// pipe_mdu_if: start/busy/done handshake and operand/result bus between
// the execute stage (master) and the multiply/divide unit (slave).
interface pipe_mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
// Shifts the dividend bit into the partial remainder, trial-subtracts the
// divisor and keeps the difference when it does not go negative.
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  // A zero divisor always "fits", so the remainder just collects the dividend bits
  assign o_qbit  = (w_shift >= {1'b0, i_divisor});
  assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
endmodule

// File: rtl/pipe_mdu.sv
// pipe_mdu: iterative MULT/MULTU/DIV/DIVU unit for the execute stage.
// IDLE -> CALC (WIDTH steps on magnitudes) -> FIX (sign correction) -> DONE.
// Optional macro MDU_EARLY_ZERO_EN: zero-result operands skip CALC.
module pipe_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic      clk,
  input  logic      rst,
  pipe_mdu_if.slave mdu
);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_mcand;    // multiplicand or divisor magnitude
  logic               r_is_div;
  logic               r_neg_res;  // negate product / quotient
  logic               r_neg_rem;  // negate remainder (dividend was negative)
  logic               r_div0;
  logic               r_zero;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [1:0]         w_state_nxt;
  logic               w_div;
  logic               w_signed;
  logic               w_early;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_rem_step;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;

  assign w_div    = op_is_div(mdu.op);
  assign w_signed = op_is_signed(mdu.op);
  assign w_mag_a  = (w_signed && mdu.a[WIDTH-1]) ? -mdu.a : mdu.a;
  assign w_mag_b  = (w_signed && mdu.b[WIDTH-1]) ? -mdu.b : mdu.b;

`ifdef MDU_EARLY_ZERO_EN
  // Result is known to be zero without iterating
  assign w_early = w_div ? ((mdu.a == {WIDTH{1'b0}}) && (mdu.b != {WIDTH{1'b0}}))
                         : ((mdu.a == {WIDTH{1'b0}}) || (mdu.b == {WIDTH{1'b0}}));
`else
  assign w_early = 1'b0;
`endif

  // Shift-add multiply step: add multiplicand when the low multiplier bit is set, then shift right
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + {1'b0, (r_acc[0] ? r_mcand : {WIDTH{1'b0}})};
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
    .i_bit     (r_acc[WIDTH-1]),
    .i_divisor (r_mcand),
    .o_rem     (w_rem_step),
    .o_qbit    (w_qbit)
  );
  assign w_div_next = {w_rem_step, r_acc[WIDTH-2:0], w_qbit};

  // Next-state selection; flush returns to IDLE from anywhere and drops a same-cycle start
  always_comb begin
    w_state_nxt = r_state;
    if (mdu.flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mdu.start) begin
            w_state_nxt = w_early ? ST_FIX : ST_CALC;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            w_state_nxt = ST_FIX;
          end else begin
            w_state_nxt = ST_CALC;
          end
        end
        ST_FIX:  w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Sign correction of the magnitude result; divide by zero forces an all-ones quotient
  always_comb begin
    w_hi_fix = {WIDTH{1'b0}};
    w_lo_fix = {WIDTH{1'b0}};
    if (r_zero) begin
      w_hi_fix = {WIDTH{1'b0}};
      w_lo_fix = {WIDTH{1'b0}};
    end else if (r_is_div) begin
      w_hi_fix = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      if (r_div0) begin
        w_lo_fix = {WIDTH{DIV0_QUOT[0]}};
      end else begin
        w_lo_fix = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      end
    end else begin
      {w_hi_fix, w_lo_fix} = r_neg_res ? -r_acc : r_acc;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_acc     <= {(2*WIDTH){1'b0}};
      r_mcand   <= {WIDTH{1'b0}};
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_zero    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_CALC) || (w_state_nxt == ST_FIX);
      r_done  <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (mdu.start && !mdu.flush) begin
            r_is_div  <= w_div;
            r_neg_res <= w_signed & (mdu.a[WIDTH-1] ^ mdu.b[WIDTH-1]);
            r_neg_rem <= w_signed & w_div & mdu.a[WIDTH-1];
            r_div0    <= w_div & (mdu.b == {WIDTH{1'b0}});
            r_zero    <= w_early;
            r_cnt     <= {CNT_W{1'b0}};
            r_mcand   <= w_div ? w_mag_b : w_mag_a;
            r_acc     <= {{WIDTH{1'b0}}, (w_div ? w_mag_a : w_mag_b)};
          end
        end
        ST_CALC: begin
          if (!mdu.flush) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (!mdu.flush) begin
            r_hi <= w_hi_fix;
            r_lo <= w_lo_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mdu.busy = r_busy;
  assign mdu.done = r_done;
  assign mdu.hi   = r_hi;
  assign mdu.lo   = r_lo;

endmodule

// File: doc/pipe_mdu.md
Name: pipe_mdu

Overview:
- Iterative multiply/divide unit attached to the execute stage of the five-stage pipeline.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and produces a HI/LO pair.
- Gives execute a start/busy/done handshake; execute holds the pipeline while busy and latches HI/LO on done.
- Sits between the decoded ALU operands and the HI/LO write path.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- a  in  WIDTH  multiplicand or dividend (ALUa).
- b  in  WIDTH  multiplier or divisor (ALUb).
- flush  in  1  abort the current operation (pipeline cancel).
- busy  out  1  operation in progress; execute stalls while high.
- done  out  1  one-cycle completion pulse.
- hi  out  WIDTH  product upper half, or remainder.
- lo  out  WIDTH  product lower half, or quotient.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and operand registers cleared.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - start=1 at edge T0 latches op/a/b, enters CALC, sets busy=1.
  - Signed ops latch operand magnitudes plus sign flags.
- CALC:
  - Multiply: one shift-add step per cycle on a 2*WIDTH accumulator.
  - Divide: one restoring step per cycle (shift remainder, trial subtract, set quotient bit).
  - Counter counts 0..WIDTH-1; leaves CALC after WIDTH edges.
- FIX (1 cycle), sign correction:
  - Signed product negated when operand signs differ.
  - Signed quotient negated when signs differ.
  - Remainder takes the sign of the dividend.
  - Writes hi/lo registers.
- DONE:
  - done=1 and busy=0 for exactly one cycle; returns to IDLE on the next edge.
  - A start seen in DONE is ignored.
- Latency: done is high in the cycle after edge T0+WIDTH+1 (cycle 34 counting T0 as cycle 0, WIDTH=32).
- hi/lo hold their value until the next FIX; they are valid from the done cycle onward.
- start while busy: ignored, no queueing.
- Divide by zero: no exception. Result lo=all-ones, hi=a (raw dividend bits), same latency, both signed and unsigned.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- flush:
  - In any non-IDLE state, next state is IDLE, busy=0, no done pulse, hi/lo unchanged.
  - Same cycle as start in IDLE: flush wins and start is dropped.
- Reset mid-operation: immediate return to reset values; no done pulse.
- Registered outputs only: busy, done, hi and lo come from flops.

Optional Feature:
- Macro: MDU_EARLY_ZERO_EN.
- Defined:
  - On start, if (op is multiply and a==0 or b==0), or (op is divide and a==0 and b!=0), the FSM goes IDLE -> FIX directly, skipping CALC.
  - Result hi=0, lo=0; done in the cycle after edge T0+1.
- Undefined: all operations take the full WIDTH+2 cycle path.

Decomposition:
- Package mdu_pkg holds:
  - Op encodings MDU_MULT/MDU_MULTU/MDU_DIV/MDU_DIVU.
  - FSM state encoding (IDLE, CALC, FIX, DONE; 2 bits).
  - DIV0_QUOT constant (all-ones).
- Sub-module mdu_div_step: combinational single restoring-division step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once in pipe_mdu.
- The multiply step stays inline.

Test Plan:
- MULT a=0xFFFFFFFE b=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; done exactly at cycle 34; busy high in cycles 1..33.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100/7 with flush asserted at cycle 10 -> busy=0 at cycle 11, no done pulse, hi/lo keep prior values. A second start pulsed at cycle 5 of a running op has no effect.
- rst pulled low at cycle 20 of a MULT -> busy/done/hi/lo=0 immediately. With MDU_EARLY_ZERO_EN, MULT a=0 b=5 -> done at cycle 2, hi=lo=0.
